// File: rtl/clk_div_mc_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// clkout generation is controlled by the CLK_DIV_MC_DUTY_OUT_EN macro in clk_div_ch.
package clk_div_mc_pkg;

  typedef enum logic [1:0] {
    RST    = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    RECONF = 2'd3
  } state_t;

  localparam int DEF_DIV_DEFAULT = 50;

  // Channel-select width; never below one bit so a single-channel build still has a port.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: stored ratio/phase, free-running counter, ce pulse and optional duty output.
// Macro CLK_DIV_MC_DUTY_OUT_EN builds the registered ~50% clkout; otherwise clkout is tied low.
module clk_div_ch
  import clk_div_mc_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int RST_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             run,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             ce,
  output logic             clkout
);

  // A zero reset ratio is treated like the runtime rule: it behaves as divide-by-1.
  localparam logic [DIV_W-1:0] RST_DIV_EFF = (RST_DIV < 1) ? DIV_W'(1) : DIV_W'(RST_DIV);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] phase_q;
  logic [DIV_W-1:0] cnt_q;
  logic             active;
  logic             at_end;

  assign active = run & en;
  assign at_end = (cnt_q == (div_q - DIV_W'(1)));

  always_ff @(posedge clkin) begin
    if (reset) begin
      div_q   <= RST_DIV_EFF;
      phase_q <= '0;
      cnt_q   <= '0;
      ce      <= 1'b0;
    end else begin
      ce <= active & at_end;
      if (wr) begin
        div_q   <= wr_div;
        phase_q <= wr_phase;
        cnt_q   <= wr_phase;
      end else if (!active) begin
        cnt_q <= phase_q;
      end else if (at_end) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

`ifdef CLK_DIV_MC_DUTY_OUT_EN
  logic [DIV_W-1:0] half;

  // ceil(D/2): odd ratios spend the extra cycle high.
  assign half = (div_q >> 1) + DIV_W'(div_q[0]);

  always_ff @(posedge clkin) begin
    if (reset) begin
      clkout <= 1'b0;
    end else begin
      clkout <= active & (cnt_q < half);
    end
  end
`else
  assign clkout = 1'b0;
`endif

endmodule

// File: rtl/clk_div_mc.sv
// Multi-channel clock-enable divider with settle/lock sequencing and runtime reconfiguration.
// Optional clkout duty waveform is enabled by defining CLK_DIV_MC_DUTY_OUT_EN.
module clk_div_mc
  import clk_div_mc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = DEF_DIV_DEFAULT,
  localparam int CH_W       = ch_idx_w(NUM_CH)
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clkout,
  output logic              lock,
  output state_t            dbg_state
);

  localparam int SC_W = (LOCK_CYCLES <= 1) ? 1 : $clog2(LOCK_CYCLES);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(LOCK_CYCLES - 1);

  state_t            state;
  logic [SC_W-1:0]   settle_cnt;
  logic [CH_W-1:0]   pend_ch;
  logic [DIV_W-1:0]  pend_div;
  logic [DIV_W-1:0]  pend_phase;
  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  phase_eff;
  logic              ch_ok;
  logic              running;
  logic [NUM_CH-1:0] wr_sel;

  assign div_eff   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign phase_eff = (cfg_phase < div_eff) ? cfg_phase : '0;
  assign ch_ok     = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
  assign running   = (state == RUN);
  assign dbg_state = state;

  // Handshake: a request transfers on any rising edge where cfg_valid && cfg_ready;
  // cfg_ch/cfg_div/cfg_phase are captured on that edge only and need not be held afterwards.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state      <= RST;
      lock       <= 1'b0;
      cfg_ready  <= 1'b0;
      settle_cnt <= '0;
      pend_ch    <= '0;
      pend_div   <= '0;
      pend_phase <= '0;
    end else begin
      case (state)
        RST: begin
          state      <= SETTLE;
          settle_cnt <= '0;
          lock       <= 1'b0;
          cfg_ready  <= 1'b0;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state     <= RUN;
            lock      <= 1'b1;
            cfg_ready <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SC_W'(1);
          end
        end
        RUN: begin
          // Out-of-range channel requests complete the handshake but change nothing.
          if (cfg_valid && cfg_ready && ch_ok) begin
            state      <= RECONF;
            lock       <= 1'b0;
            cfg_ready  <= 1'b0;
            pend_ch    <= cfg_ch;
            pend_div   <= div_eff;
            pend_phase <= phase_eff;
          end
        end
        RECONF: begin
          state      <= SETTLE;
          settle_cnt <= '0;
          lock       <= 1'b0;
          cfg_ready  <= 1'b0;
        end
        default: begin
          state     <= RST;
          lock      <= 1'b0;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_sel[i] = (state == RECONF) && (pend_ch == CH_W'(i));

    clk_div_ch #(
      .DIV_W   (DIV_W),
      .RST_DIV (DEF_DIV)
    ) u_ch (
      .clkin    (clkin),
      .reset    (reset),
      .run      (running),
      .en       (ch_en[i]),
      .wr       (wr_sel[i]),
      .wr_div   (pend_div),
      .wr_phase (pend_phase),
      .ce       (ce[i]),
      .clkout   (clkout[i])
    );
  end

endmodule

// File: tb/tb_clk_div_mc.sv
// Bench for clk_div_mc: per-cycle reference model, table-driven reconfiguration vectors,
// hand sequences for reset/enable corners, and a 3-channel instance for out-of-range requests.
`timescale 1ns/1ps
module tb_clk_div_mc;
  import clk_div_mc_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DIV_W = 16;
  localparam int LOCK_CYCLES = 16;
  localparam int DEF_DIV = 50;
  localparam int CH_W = 2;

  // clock / reset
  logic clkin = 1'b0;
  always #5 clkin = ~clkin;

  logic              reset = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [DIV_W-1:0]  cfg_phase = '0;
  logic [NUM_CH-1:0] ch_en = '1;
  logic              cfg_ready;
  logic              lock;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] clkout;
  state_t            dbg_state;

  logic       o_valid = 1'b0;
  logic [1:0] o_ch = '0;
  logic [7:0] o_div = '0;
  logic [7:0] o_phase = '0;
  logic [2:0] o_en = '1;
  logic       o_ready;
  logic       o_lock;
  logic [2:0] o_ce;
  logic [2:0] o_clk;
  state_t     o_state;

  clk_div_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES), .DEF_DIV(DEF_DIV)) dut (
    .clkin(clkin), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .ch_en(ch_en),
    .ce(ce), .clkout(clkout), .lock(lock), .dbg_state(dbg_state)
  );

  clk_div_mc #(.NUM_CH(3), .DIV_W(8), .LOCK_CYCLES(2), .DEF_DIV(4)) u_oor (
    .clkin(clkin), .reset(reset), .cfg_valid(o_valid), .cfg_ready(o_ready),
    .cfg_ch(o_ch), .cfg_div(o_div), .cfg_phase(o_phase), .ch_en(o_en),
    .ce(o_ce), .clkout(o_clk), .lock(o_lock), .dbg_state(o_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: cycles-to-lock countdown and per-channel (P + k) mod D counting
  int m_wait;
  int m_D[NUM_CH];
  int m_P[NUM_CH];
  int m_k[NUM_CH];
  logic [NUM_CH-1:0] m_ce;
  logic [NUM_CH-1:0] m_clk;
  bit m_pend;
  int m_pch, m_pd, m_pp;

  task automatic model_step();
    bit was_run;
    int cv;
    if (reset) begin
      m_wait = LOCK_CYCLES + 1;
      m_pend = 0;
      m_ce = '0;
      m_clk = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_D[i] = DEF_DIV; m_P[i] = 0; m_k[i] = 0;
      end
      return;
    end
    was_run = (m_wait == 0);
    for (int i = 0; i < NUM_CH; i++) begin
      if (was_run && ch_en[i]) begin
        cv = (m_P[i] + m_k[i]) % m_D[i];
        m_ce[i] = (cv == m_D[i] - 1);
        m_clk[i] = (cv < (m_D[i] + 1) / 2);
        m_k[i]++;
      end else begin
        m_ce[i] = 1'b0; m_clk[i] = 1'b0; m_k[i] = 0;
      end
    end
    if (m_pend) begin
      m_D[m_pch] = m_pd; m_P[m_pch] = m_pp; m_pend = 0;
    end
    if (was_run) begin
      if (cfg_valid && int'(cfg_ch) < NUM_CH) begin
        m_pend = 1;
        m_pch = int'(cfg_ch);
        m_pd = (cfg_div == 0) ? 1 : int'(cfg_div);
        m_pp = (int'(cfg_phase) < m_pd) ? int'(cfg_phase) : 0;
        m_wait = LOCK_CYCLES + 1;
      end
    end else begin
      m_wait--;
    end
  endtask

  initial forever begin
    @(posedge clkin);
    model_step();
  end

  initial begin
    logic [NUM_CH-1:0] exp_clk;
    @(posedge clkin);
    forever begin
      @(negedge clkin);
`ifdef CLK_DIV_MC_DUTY_OUT_EN
      exp_clk = m_clk;
`else
      exp_clk = '0;
`endif
      check("model_lock", 32'(lock), 32'(m_wait == 0));
      check("model_cfg_ready", 32'(cfg_ready), 32'(m_wait == 0));
      check("model_ce", 32'(ce), 32'(m_ce));
      check("model_clkout", 32'(clkout), 32'(exp_clk));
    end
  end

  // driver tasks
  task automatic do_cfg(input int ch, input int div, input int ph);
    int n = 0;
    while (!cfg_ready && n < 200) begin
      @(negedge clkin); n++;
    end
    check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_ch = CH_W'(ch);
    cfg_div = DIV_W'(div);
    cfg_phase = DIV_W'(ph);
    @(negedge clkin);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_lock(output int low);
    low = 0;
    while (!lock && low < 200) begin
      low++;
      @(negedge clkin);
    end
  endtask

  // Called at the first negedge of a counting window; idx 1 is the cycle after that.
  task automatic measure(input int ch, input string name, input int exp_first, input int exp_period);
    int first = -1;
    int second = -1;
    for (int idx = 1; idx <= 200 && second < 0; idx++) begin
      @(negedge clkin);
      if (ce[ch]) begin
        if (first < 0) first = idx;
        else second = idx;
      end
    end
    check({name, "_first_ce"}, first, exp_first);
    check({name, "_period"}, second - first, exp_period);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_lock"}, 32'(lock), 32'd0);
    check({name, "_ready"}, 32'(cfg_ready), 32'd0);
    check({name, "_ce"}, 32'(ce), 32'd0);
    check({name, "_clkout"}, 32'(clkout), 32'd0);
    check({name, "_state"}, 32'(dbg_state), 32'(RST));
  endtask

  typedef struct {
    int ch;
    int div;
    int phase;
    int exp_first;
    int exp_period;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int low;
    int idx;
    int first;
    int second;

    tbl[0] = '{ch: 1, div: 3, phase: 2, exp_first: 1, exp_period: 3};
    tbl[1] = '{ch: 2, div: 0, phase: 0, exp_first: 1, exp_period: 1};
    tbl[2] = '{ch: 3, div: 4, phase: 9, exp_first: 4, exp_period: 4};
    tbl[3] = '{ch: 0, div: 5, phase: 1, exp_first: 4, exp_period: 5};
    tbl[4] = '{ch: 2, div: 2, phase: 1, exp_first: 1, exp_period: 2};
    tbl[5] = '{ch: 3, div: 7, phase: 6, exp_first: 1, exp_period: 7};
    tbl[6] = '{ch: 0, div: 10, phase: 3, exp_first: 7, exp_period: 10};

    repeat (3) @(negedge clkin);
    check_reset_vals("reset");
    reset = 1'b0;
    wait_lock(low);
    check("lock_latency", low, LOCK_CYCLES + 1);
    measure(0, "default_ch0", DEF_DIV, DEF_DIV);

    for (int v = 0; v < 7; v++) begin
      do_cfg(tbl[v].ch, tbl[v].div, tbl[v].phase);
      check($sformatf("vec%0d_ready_drop", v), 32'(cfg_ready), 32'd0);
      wait_lock(low);
      check($sformatf("vec%0d_lock_low", v), low, LOCK_CYCLES + 1);
      measure(tbl[v].ch, $sformatf("vec%0d", v), tbl[v].exp_first, tbl[v].exp_period);
    end

    // ch0 is D=10 P=3: disable, confirm lock holds, re-enable and restart from phase
    ch_en[0] = 1'b0;
    repeat (20) @(negedge clkin);
    check("disable_lock", 32'(lock), 32'd1);
    check("disable_ce0", 32'(ce[0]), 32'd0);
    ch_en[0] = 1'b1;
    measure(0, "reenable_ch0", 7, 10);

    // reset mid-SETTLE discards the pending configuration
    do_cfg(1, 3, 2);
    repeat (5) @(negedge clkin);
    reset = 1'b1;
    @(negedge clkin);
    check_reset_vals("rst_settle");
    reset = 1'b0;
    wait_lock(low);
    check("rst_settle_relock", low, LOCK_CYCLES + 1);
    measure(1, "rst_settle_ch1", DEF_DIV, DEF_DIV);

    // reset during the RECONF cycle
    do_cfg(2, 5, 0);
    check("reconf_state", 32'(dbg_state), 32'(RECONF));
    reset = 1'b1;
    @(negedge clkin);
    check_reset_vals("rst_reconf");
    reset = 1'b0;
    wait_lock(low);
    check("rst_reconf_relock", low, LOCK_CYCLES + 1);
    measure(2, "rst_reconf_ch2", DEF_DIV, DEF_DIV);

    // randomized traffic, including requests while not ready
    for (int c = 0; c < 1500; c++) begin
      @(negedge clkin);
      cfg_valid = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, NUM_CH - 1);
        ch_en[idx] = ~ch_en[idx];
      end
      if ($urandom_range(0, 39) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch = CH_W'($urandom_range(0, NUM_CH - 1));
        cfg_div = DIV_W'($urandom_range(0, 12));
        cfg_phase = DIV_W'($urandom_range(0, 15));
      end
    end
    @(negedge clkin);
    cfg_valid = 1'b0;
    ch_en = '1;

    // out-of-range channel on the 3-channel instance is ignored
    check("oor_ready_before", 32'(o_ready), 32'd1);
    o_valid = 1'b1; o_ch = 2'd3; o_div = 8'd7; o_phase = 8'd1;
    @(negedge clkin);
    o_valid = 1'b0;
    check("oor_lock", 32'(o_lock), 32'd1);
    check("oor_state", 32'(o_state), 32'(RUN));
    first = -1; second = -1;
    for (int i = 1; i <= 40 && second < 0; i++) begin
      @(negedge clkin);
      if (o_ce[0]) begin
        if (first < 0) first = i;
        else second = i;
      end
    end
    check("oor_ch0_period", second - first, 4);
    o_valid = 1'b1; o_ch = 2'd2; o_div = 8'd3; o_phase = 8'd0;
    @(negedge clkin);
    o_valid = 1'b0;
    check("inrange_lock_drop", 32'(o_lock), 32'd0);

    repeat (5) @(negedge clkin);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
